clk_div_ctrl: RTL and testbench

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

---
 rtl/clk_div_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_clk_div_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable clock divider with clean run/stop control and a one-deep divisor handshake.
// Optional build macro CLK_DIV_CTRL_ERR_EN: zero divisors are rejected and reported on cfg_err.
module clk_div_ctrl #(
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
`ifdef CLK_DIV_CTRL_ERR_EN
    ,
    output logic             cfg_err
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;

    localparam logic [DIV_W-1:0] ZERO_DIV  = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] ONE_DIV   = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DEF_RAW   = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RESET_DIV = (DEF_RAW == ZERO_DIV) ? ONE_DIV : DEF_RAW;

    // A zero half-period cannot be counted; the smallest legal divisor is used instead.
    function automatic logic [DIV_W-1:0] norm_div(input logic [DIV_W-1:0] d);
        if (d == ZERO_DIV) begin
            return ONE_DIV;
        end else begin
            return d;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_ready_q, cfg_ready_d;

    logic             accept_s;
    logic             wrap_s;
    logic             count_s;
    logic             wrap_edge_s;
    logic             div_bad_s;
    logic [DIV_W-1:0] new_div_s;
    logic             ld_vld_s;
    logic [DIV_W-1:0] ld_div_s;
    logic             acc_vld_s;
    logic [DIV_W-1:0] acc_pend_s;
    logic [DIV_W-1:0] acc_cur_s;

`ifdef CLK_DIV_CTRL_ERR_EN
    logic cfg_err_q, cfg_err_d;
    assign div_bad_s = (cfg_div == ZERO_DIV);
    assign new_div_s = cfg_div;
`else
    assign div_bad_s = 1'b0;
    assign new_div_s = norm_div(cfg_div);
`endif

    assign accept_s = cfg_valid & cfg_ready_q;
    assign wrap_s   = (cnt_q >= (cur_div_q - ONE_DIV));

    // State transitions and divided-clock generation.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        count_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d     = ZERO_DIV;
                clk_out_d = 1'b0;
                if (run) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!run && !clk_out_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = ZERO_DIV;
                end else begin
                    count_s = 1'b1;
                    if (run) begin
                        state_d = ST_RUN;
                    end else if (wrap_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // clk_out is high here, so the wrap is always the falling edge.
                count_s = 1'b1;
                if (run) begin
                    state_d = ST_RUN;
                end else if (wrap_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = ZERO_DIV;
                clk_out_d = 1'b0;
            end
        endcase

        wrap_edge_s = count_s & wrap_s;
        if (count_s && wrap_s) begin
            cnt_d     = ZERO_DIV;
            clk_out_d = ~clk_out_q;
        end else if (count_s) begin
            cnt_d = cnt_q + ONE_DIV;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Divisor handshake: wrap load first, then the new accept, then flush on the way to IDLE.
    always_comb begin
        if (wrap_edge_s && pend_vld_q) begin
            ld_vld_s = 1'b0;
            ld_div_s = pend_div_q;
        end else begin
            ld_vld_s = pend_vld_q;
            ld_div_s = cur_div_q;
        end

        acc_vld_s  = ld_vld_s;
        acc_pend_s = pend_div_q;
        acc_cur_s  = ld_div_s;
        if (accept_s && !div_bad_s && (state_q == ST_IDLE)) begin
            acc_cur_s = new_div_s;
        end else if (accept_s && !div_bad_s) begin
            acc_vld_s  = 1'b1;
            acc_pend_s = new_div_s;
        end else begin
            acc_cur_s = ld_div_s;
        end

        if ((state_d == ST_IDLE) && acc_vld_s) begin
            cur_div_d  = acc_pend_s;
            pend_vld_d = 1'b0;
        end else begin
            cur_div_d  = acc_cur_s;
            pend_vld_d = acc_vld_s;
        end
        pend_div_d  = acc_pend_s;
        cfg_ready_d = ~pend_vld_d;
        busy_d      = (state_d != ST_IDLE);
        tick_d      = clk_out_d & ~clk_out_q;
    end

    // Register bank; reset drops clk_out and discards any pending divisor at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= ZERO_DIV;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            busy_q      <= 1'b0;
            cur_div_q   <= RESET_DIV;
            pend_vld_q  <= 1'b0;
            pend_div_q  <= ZERO_DIV;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            busy_q      <= busy_d;
            cur_div_q   <= cur_div_d;
            pend_vld_q  <= pend_vld_d;
            pend_div_q  <= pend_div_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

`ifdef CLK_DIV_CTRL_ERR_EN
    // Rejected zero divisor flag, one cycle after the accepting edge.
    always_comb begin
        if (accept_s && div_bad_s) begin
            cfg_err_d = 1'b1;
        end else begin
            cfg_err_d = 1'b0;
        end
    end

    // Error pulse register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;
`endif

    assign cfg_ready = cfg_ready_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign busy      = busy_q;
    assign cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized bench for clk_div_ctrl against a phase-length reference model.
module tb_clk_div_ctrl;

    localparam int DIV_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             busy;
    logic [DIV_W-1:0] cur_div;
`ifdef CLK_DIV_CTRL_ERR_EN
    logic             cfg_err;
`endif

    clk_div_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
`ifdef CLK_DIV_CTRL_ERR_EN
        ,
        .cfg_err   (cfg_err)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a phase lasts m_div edges; a pending divisor waits in a queue.
    logic        m_active, m_clk, m_tick, m_ready, m_err;
    logic [31:0] m_div;
    int          m_left;
    logic [31:0] m_pq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_clk    = 1'b0;
        m_tick   = 1'b0;
        m_ready  = 1'b1;
        m_err    = 1'b0;
        m_div    = 32'd1;
        m_left   = 0;
        m_pq.delete();
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [31:0] d);
        logic        acc, prev_clk, bad;
        logic [31:0] eff;
        acc      = v && m_ready;
        prev_clk = m_clk;
`ifdef CLK_DIV_CTRL_ERR_EN
        bad = (d == 32'd0);
        eff = d;
`else
        bad = 1'b0;
        eff = (d == 32'd0) ? 32'd1 : d;
`endif
        m_err = acc && bad;
        if (!m_active) begin
            if (acc && !bad) m_div = eff;
            if (r) begin
                m_active = 1'b1;
                m_left   = int'(m_div);
            end
        end else if (!r && !m_clk) begin
            m_active = 1'b0;
            if (acc && !bad) m_pq.push_back(eff);
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_clk = !m_clk;
                if (m_pq.size() > 0) m_div = m_pq.pop_front();
                m_left = int'(m_div);
                if (!m_clk && !r) m_active = 1'b0;
            end
            if (acc && !bad) m_pq.push_back(eff);
        end
        if (!m_active) begin
            while (m_pq.size() > 0) m_div = m_pq.pop_front();
        end
        m_tick  = m_clk && !prev_clk;
        m_ready = (m_pq.size() == 0);
    endtask

    task automatic compare_all(input string pfx);
        check_eq({pfx, "_clk_out"}, {31'd0, clk_out}, {31'd0, m_clk});
        check_eq({pfx, "_tick"}, {31'd0, tick}, {31'd0, m_tick});
        check_eq({pfx, "_busy"}, {31'd0, busy}, {31'd0, m_active});
        check_eq({pfx, "_cur_div"}, cur_div, m_div);
        check_eq({pfx, "_cfg_ready"}, {31'd0, cfg_ready}, {31'd0, m_ready});
`ifdef CLK_DIV_CTRL_ERR_EN
        check_eq({pfx, "_cfg_err"}, {31'd0, cfg_err}, {31'd0, m_err});
`endif
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d);
        run       = r;
        cfg_valid = v;
        cfg_div   = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        compare_all("cyc");
    endtask

    task automatic stop_idle();
        for (int i = 0; i < 40 && m_active; i++) step(1'b0, 1'b0, 32'd0);
        check_eq("stop_idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_high();
        for (int i = 0; i < 40 && !m_clk; i++) step(1'b1, 1'b0, 32'd0);
        check_eq("wait_high_clk_out", {31'd0, clk_out}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int highs;
        logic was_ready;
        logic got_acc;

        rst = 1'b0; run = 1'b0; cfg_valid = 1'b0; cfg_div = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // clk/2 with the default divisor
        step(1'b1, 1'b0, 32'd0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 32'd0);
            ticks += int'(tick);
        end
        check_eq("div1_ticks", ticks, 32'd10);
        stop_idle();

        // divisor change 3 -> 5 mid-phase
        step(1'b0, 1'b1, 32'd3);
        repeat (7) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd5);
        check_eq("chg_pending_ready", {31'd0, cfg_ready}, 32'd0);
        check_eq("chg_cur_still_3", cur_div, 32'd3);
        repeat (25) step(1'b1, 1'b0, 32'd0);

        // back-to-back writes 6 then 7
        step(1'b1, 1'b1, 32'd6);
        got_acc = 1'b0;
        for (int i = 0; i < 40 && !got_acc; i++) begin
            was_ready = m_ready;
            step(1'b1, 1'b1, 32'd7);
            got_acc = was_ready;
        end
        check_eq("b2b_second_accepted", {31'd0, got_acc}, 32'd1);
        repeat (30) step(1'b1, 1'b0, 32'd0);
        stop_idle();

        // drain: stop one cycle into a 4-cycle high phase
        step(1'b0, 1'b1, 32'd4);
        step(1'b1, 1'b0, 32'd0);
        wait_high();
        step(1'b1, 1'b0, 32'd0);
        ticks = 0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 32'd0);
            ticks += int'(tick);
            highs += int'(clk_out);
        end
        check_eq("drain_ticks", ticks, 32'd0);
        check_eq("drain_high_cycles", highs, 32'd2);
        check_eq("drain_busy", {31'd0, busy}, 32'd0);

        // zero divisor in IDLE
        step(1'b0, 1'b1, 32'd0);
`ifdef CLK_DIV_CTRL_ERR_EN
        check_eq("zero_err_pulse", {31'd0, cfg_err}, 32'd1);
        check_eq("zero_cur_kept", cur_div, 32'd4);
`else
        check_eq("zero_cur_one", cur_div, 32'd1);
`endif
        step(1'b0, 1'b0, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = (i % 400 < 340) ? ($urandom_range(0, 31) != 0) : ($urandom_range(0, 3) == 0);
            step(r, ($urandom_range(0, 3) == 0), 32'($urandom_range(0, 6)));
        end
        stop_idle();

        // async reset in a high phase with divisor 9 pending
        step(1'b0, 1'b1, 32'd4);
        step(1'b1, 1'b0, 32'd0);
        wait_high();
        step(1'b1, 1'b1, 32'd9);
        check_eq("pre_rst_pending", {31'd0, cfg_ready}, 32'd0);
        cfg_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        repeat (2) @(posedge clk);
        #1;
        compare_all("in_rst");
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        repeat (12) step(1'b1, 1'b0, 32'd0);
        check_eq("post_rst_cur_div", cur_div, 32'd1);
        stop_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
